// File: rtl/rangefinder_vga_pkg.sv
// Shared constants, types and address helper for the rangefinder VGA render back end.
// Timing is 640x480@60 on a 25 MHz pixel strobe; the bitmap is 80x60 cells of 8x8 pixels.
package rangefinder_vga_pkg;

    localparam int CNT_W = 10;

    localparam logic [CNT_W-1:0] H_ACTIVE = 10'd640;
    localparam logic [CNT_W-1:0] H_FP     = 10'd16;
    localparam logic [CNT_W-1:0] H_SYNC   = 10'd96;
    localparam logic [CNT_W-1:0] H_BP     = 10'd48;
    localparam logic [CNT_W-1:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [CNT_W-1:0] H_LAST   = H_TOTAL - 10'd1;
    localparam logic [CNT_W-1:0] HS_START = H_ACTIVE + H_FP;
    localparam logic [CNT_W-1:0] HS_END   = HS_START + H_SYNC;

    localparam logic [CNT_W-1:0] V_ACTIVE = 10'd480;
    localparam logic [CNT_W-1:0] V_FP     = 10'd10;
    localparam logic [CNT_W-1:0] V_SYNC   = 10'd2;
    localparam logic [CNT_W-1:0] V_BP     = 10'd33;
    localparam logic [CNT_W-1:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] V_LAST   = V_TOTAL - 10'd1;
    localparam logic [CNT_W-1:0] VS_START = V_ACTIVE + V_FP;
    localparam logic [CNT_W-1:0] VS_END   = VS_START + V_SYNC;

    localparam int               CELL_SHIFT = 3;
    localparam logic [6:0]       GRID_W     = 7'd80;
    localparam logic [5:0]       GRID_H     = 6'd60;
    localparam int               ADDR_W     = 13;
    localparam int               CELL_COUNT = 4800;
    localparam logic [ADDR_W-1:0] CELL_LAST = 13'd4799;

    typedef logic [11:0] rgb444_t;
    localparam rgb444_t FG_COLOR = 12'hFFF;
    localparam rgb444_t BG_COLOR = 12'h000;

    typedef enum logic {
        CLR_RUN  = 1'b0,
        CLR_IDLE = 1'b1
    } clr_state_t;

    // row*80 + col as two shifts and an add; row never exceeds 65, so 13 bits suffice
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [CNT_W-1:0] row,
                                                    input logic [CNT_W-1:0] col);
        logic [ADDR_W-1:0] r;
        r = {3'd0, row};
        return (r << 6) + (r << 4) + {3'd0, col};
    endfunction

endpackage

// File: rtl/rangefinder_vga_timing.sv
// Horizontal/vertical scan counters advancing on pix_ce, with raw sync, active and
// frame-origin decodes taken straight from the counters.
module rangefinder_vga_timing
    import rangefinder_vga_pkg::*;
(
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             origin
);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
    assign hs_raw = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs_raw = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    assign origin = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/rangefinder_vga_render.sv
// Occupancy bitmap with plot handshake and clear engine, scanned out as 640x480 VGA
// through a two-beat pipeline (address/read, then output registers).
module rangefinder_vga_render
    import rangefinder_vga_pkg::*;
(
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       pix_ce,
    input  logic       pt_valid,
    output logic       pt_ready,
    input  logic [6:0] pt_x,
    input  logic [5:0] pt_y,
    input  logic       pt_set,
    input  logic       clr_req,
    output logic       clr_busy,
    output logic       oor_flag,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       frame_start
);

    logic [CNT_W-1:0]  h_cnt, v_cnt;
    logic              active, hs_raw, vs_raw, origin;

    clr_state_t        clr_state;
    logic [ADDR_W-1:0] clr_addr;

    logic              pt_fire, pt_in_range;
    logic              we, wdata;
    logic [ADDR_W-1:0] waddr, raddr;
    logic              mem [0:CELL_COUNT-1];
    logic              rd_bit;

    logic              act_d1, hs_d1, vs_d1, org_d1;
    rgb444_t           rgb_q;

    rangefinder_vga_timing u_timing (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .pix_ce (pix_ce),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (active),
        .hs_raw (hs_raw),
        .vs_raw (vs_raw),
        .origin (origin)
    );

    // Handshake: a command transfers on any cycle where pt_valid and pt_ready are both high.
    assign pt_fire     = pt_valid & pt_ready;
    assign pt_in_range = (pt_x < GRID_W) && (pt_y < GRID_H);

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = 1'b0;
        if (clr_state == CLR_RUN) begin
            we    = 1'b1;
            waddr = clr_addr;
        end else if (pt_fire && pt_in_range) begin
            we    = 1'b1;
            waddr = cell_addr({4'd0, pt_y}, {3'd0, pt_x});
            wdata = pt_set;
        end
    end

    // Clear engine; reset parks it at RUN so power-up garbage is wiped on release.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            clr_state <= CLR_RUN;
            clr_addr  <= '0;
            clr_busy  <= 1'b1;
            pt_ready  <= 1'b0;
            oor_flag  <= 1'b0;
        end else if (clr_state == CLR_RUN) begin
            if (clr_addr == CELL_LAST) begin
                clr_state <= CLR_IDLE;
                clr_addr  <= '0;
                clr_busy  <= 1'b0;
                pt_ready  <= 1'b1;
            end else begin
                clr_addr <= clr_addr + 13'd1;
            end
        end else begin
            if (pt_fire && !pt_in_range) begin
                oor_flag <= 1'b1;
            end
            if (clr_req) begin
                clr_state <= CLR_RUN;
                clr_addr  <= '0;
                clr_busy  <= 1'b1;
                pt_ready  <= 1'b0;
                oor_flag  <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Blanking addresses can exceed the bitmap, so park the read at 0 outside the active area.
    assign raddr = active ? cell_addr(v_cnt >> CELL_SHIFT, h_cnt >> CELL_SHIFT) : '0;

    always_ff @(posedge ACLK) begin
        if (pix_ce) begin
            rd_bit <= mem[raddr];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            act_d1      <= 1'b0;
            hs_d1       <= 1'b1;
            vs_d1       <= 1'b1;
            org_d1      <= 1'b0;
            rgb_q       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce & org_d1;
            if (pix_ce) begin
                act_d1 <= active;
                hs_d1  <= hs_raw;
                vs_d1  <= vs_raw;
                org_d1 <= origin;
                rgb_q  <= act_d1 ? (rd_bit ? FG_COLOR : BG_COLOR) : '0;
                vga_hs <= hs_d1;
                vga_vs <= vs_d1;
            end
        end
    end

    assign vga_r = rgb_q[11:8];
    assign vga_g = rgb_q[7:4];
    assign vga_b = rgb_q[3:0];

endmodule
